multicycle_control: RTL and testbench

- Moore FSM that sequences a multi-cycle version of the RV32I datapath: PC, IR/old_pc latch, register file, imm_gen, ALU and a single shared instruction/data memory.
- Replaces the single-cycle `control` block when the datapath is split into fetch / decode / execute / memory / write-back steps.
- Drives all datapath enables and mux selects from its current state and the latched opcode.
- Stalls on a memory ready handshake, counts retired instructions and traps on unsupported opcodes.

---
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Sequencer for the multi-cycle RV32I datapath (fetch/decode/execute/memory/write-back).
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   opcode                       latched IR opcode, used in DECODE and MEM_ADDR only
//   mem_ready                    memory handshake, used in FETCH/MEM_READ/MEM_WRITE only
//   PCWrite..PCSource            datapath enables and mux selects
//   trap                         unsupported opcode seen, core halted
//   state_dbg                    current state encoding
//   instr_retired, cycle_count   free-running wrapping counters
module multicycle_control #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned STATE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               PCSource,
    output logic               trap,
    output logic [STATE_W-1:0] state_dbg,
    output logic [CNT_W-1:0]   instr_retired,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd15
    } state_e;

    state_e           state_q, state_d;
    logic             retire_c;
    logic             trap_q;
    logic [CNT_W-1:0] instr_q;
    logic [CNT_W-1:0] cycle_q;

    // Next-state selection; retire_c marks the edge that completes an instruction.
    always_comb begin
        state_d  = S_TRAP;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_MEM_WRITE: begin
                state_d  = mem_ready ? S_FETCH : S_MEM_WRITE;
                retire_c = mem_ready;
            end
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_ALU_WB, S_BRANCH: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    // State, trap flag and counters; cycle_count freezes once halted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            trap_q  <= 1'b0;
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            trap_q  <= (state_d == S_TRAP);
            if (state_q != S_TRAP) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (retire_c) begin
                instr_q <= instr_q + CNT_W'(1);
            end
        end
    end

    // Moore decode of the current state; FETCH gates IR/PC loads with mem_ready.
    // Reset masks everything so a write in flight is dropped without waiting for an edge.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b10;
            end
            S_ALU_WB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 2'b10;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 1'b0;
        end
    end

    assign trap          = trap_q;
    assign state_dbg     = STATE_W'(state_q);
    assign instr_retired = instr_q;
    assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences push
// hand-derived expectations; a negedge monitor pops and compares every cycle.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegWrite, PCSource, trap;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0]  state_dbg;
    logic [31:0] instr_retired, cycle_count;

    multicycle_control #(.CNT_W(32), .STATE_W(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .trap(trap),
        .state_dbg(state_dbg), .instr_retired(instr_retired),
        .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic [31:0] ret;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_n  = 0;

    // Control word {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,
    //               ALUSrcA,ALUSrcB,ALUOp,PCSource,trap} expected in each state.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, rw, pcs, tr;
        logic [1:0] a, b, op;
        {pcw, pcc, iord, mrd, mwr, irw, m2r, rw, pcs, tr} = '0;
        a = 2'b00; b = 2'b00; op = 2'b00;
        case (st)
            4'd0:  begin pcw = mr; mrd = 1'b1; irw = mr; b = 2'b01; end
            4'd1:  begin a = 2'b01; b = 2'b10; end
            4'd2:  begin a = 2'b10; b = 2'b10; end
            4'd3:  begin iord = 1'b1; mrd = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin iord = 1'b1; mwr = 1'b1; end
            4'd6:  begin a = 2'b10; b = 2'b00; op = 2'b10; end
            4'd7:  begin a = 2'b10; b = 2'b10; op = 2'b10; end
            4'd8:  begin rw = 1'b1; end
            4'd9:  begin a = 2'b10; op = 2'b01; pcc = 1'b1; pcs = 1'b1; end
            4'd15: begin tr = 1'b1; end
            default: ;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rw, a, b, op, pcs, tr};
    endfunction

    // One clock cycle of stimulus with its expected outputs.
    task automatic step(input logic [6:0] op, input logic mr, input logic [3:0] st,
                        input int unsigned ret, input int unsigned cyc);
        exp_t e;
        opcode    = op;
        mem_ready = mr;
        e.st   = st;
        e.ctrl = exp_ctrl(st, mr);
        e.ret  = 32'(ret);
        e.cyc  = 32'(cyc);
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Raise reset away from any edge; outputs must clear before the next edge.
    task automatic do_reset();
        exp_t e;
        reset     = 1'b1;
        mem_ready = 1'b1;
        e = '0;
        q.push_back(e);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare DUT against the oldest expectation each cycle.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = q.pop_front();
            act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, trap};
            checks += 4;
            if (state_dbg !== e.st) begin
                errors++;
                $display("FAIL state vec%0d: got %0d want %0d", vec_n, state_dbg, e.st);
            end
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl vec%0d (state %0d): got %b want %b", vec_n, e.st, act, e.ctrl);
            end
            if (instr_retired !== e.ret) begin
                errors++;
                $display("FAIL retired vec%0d: got %0d want %0d", vec_n, instr_retired, e.ret);
            end
            if (cycle_count !== e.cyc) begin
                errors++;
                $display("FAIL cycles vec%0d: got %0d want %0d", vec_n, cycle_count, e.cyc);
            end
            vec_n++;
        end
    end

    initial begin
        @(posedge clock);
        #1;
        do_reset();

        // R-type: 0,1,6,8 then back to FETCH with one retired
        step(RT, 1, 0, 0, 0);
        step(RT, 1, 1, 0, 1);
        step(RT, 1, 6, 0, 2);
        step(RT, 1, 8, 0, 3);
        // load with two not-ready cycles in MEM_READ
        step(LD, 1, 0, 1, 4);
        step(LD, 1, 1, 1, 5);
        step(LD, 1, 2, 1, 6);
        step(LD, 0, 3, 1, 7);
        step(LD, 0, 3, 1, 8);
        step(LD, 1, 3, 1, 9);
        step(LD, 1, 4, 1, 10);
        // store then branch
        step(ST, 1, 0, 2, 11);
        step(ST, 1, 1, 2, 12);
        step(ST, 1, 2, 2, 13);
        step(ST, 1, 5, 2, 14);
        step(BR, 1, 0, 3, 15);
        step(BR, 1, 1, 3, 16);
        step(BR, 1, 9, 3, 17);
        step(BR, 1, 0, 4, 18);

        // FETCH stall of three cycles right after reset, then I-type
        do_reset();
        step(IT, 0, 0, 0, 0);
        step(IT, 0, 0, 0, 1);
        step(IT, 0, 0, 0, 2);
        step(IT, 1, 0, 0, 3);
        step(IT, 1, 1, 0, 4);
        step(IT, 1, 7, 0, 5);
        step(IT, 1, 8, 0, 6);
        // illegal opcode traps; counters frozen, strobes stay low
        step(BAD, 1, 0, 1, 7);
        step(BAD, 1, 1, 1, 8);
        step(BAD, 1, 15, 1, 9);
        for (int i = 0; i < 10; i++) begin
            step((i % 2 == 0) ? LD : BAD, 1'(i % 2), 15, 1, 9);
        end

        // reset leaves TRAP; then store stalled in MEM_WRITE hit by async reset
        do_reset();
        step(ST, 1, 0, 0, 0);
        step(ST, 1, 1, 0, 1);
        step(ST, 1, 2, 0, 2);
        step(ST, 0, 5, 0, 3);
        step(ST, 0, 5, 0, 4);
        do_reset();
        // branch after recovery
        step(BR, 1, 0, 0, 0);
        step(BR, 1, 1, 0, 1);
        step(BR, 1, 9, 0, 2);
        step(BR, 1, 0, 1, 3);

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
